// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall FSM encoding and register-index width.
package pipe_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      IMEM_WAIT = 2'd1,
      DMEM_WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in ID/EX writes a register the IF/ID instruction reads.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic             memread,
   input  logic [REG_W-1:0] ld_rd,
   input  logic [REG_W-1:0] src_a,
   input  logic [REG_W-1:0] src_b,
   output logic             lu
);

   // r0 is hardwired zero, so a load targeting it never creates a dependency
   assign lu = memread && (ld_rd != '0) && ((ld_rd == src_a) || (ld_rd == src_b));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller: same-cycle hazard controls plus a wait-episode FSM
// feeding a saturating stall counter and a sticky memory-timeout flag.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rt,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_busy,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_freeze,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             timeout_err,
   output logic [1:0]       state
);

   localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

   logic        lu;
   state_t      st, st_nxt;
   logic [15:0] wcnt, wcnt_nxt;

   hazard_detect u_hd (
      .memread (idex_memread),
      .ld_rd   (idex_rt),
      .src_a   (ifid_rs),
      .src_b   (ifid_rt),
      .lu      (lu)
   );

   // freeze > branch flush > fetch wait > load-use
   always_comb begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_freeze = 1'b0;
      if (dmem_busy) begin
         pipe_freeze = 1'b1;
         pc_hold     = 1'b1;
         ifid_hold   = 1'b1;
      end else if (branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (!imem_ready) begin
         pc_hold     = 1'b1;
         ifid_flush  = 1'b1;
      end else if (lu) begin
         pc_hold     = 1'b1;
         ifid_hold   = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   always_comb begin
      st_nxt = st;
      case (st)
         RUN: begin
            if (dmem_busy)                        st_nxt = DMEM_WAIT;
            else if (!imem_ready && !branch_taken) st_nxt = IMEM_WAIT;
         end
         IMEM_WAIT: begin
            if (dmem_busy)                        st_nxt = DMEM_WAIT;
            else if (imem_ready || branch_taken)  st_nxt = RUN;
         end
         DMEM_WAIT: begin
            if (!dmem_busy) st_nxt = imem_ready ? RUN : IMEM_WAIT;
         end
         default: st_nxt = RUN;
      endcase
   end

   always_comb begin
      wcnt_nxt = '0;
      if (st_nxt == st && st != RUN)
         wcnt_nxt = (wcnt == TO_LIM) ? wcnt : wcnt + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= RUN;
         wcnt        <= '0;
         stall_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         st   <= st_nxt;
         wcnt <= wcnt_nxt;
         if (pc_hold && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (wcnt_nxt == TO_LIM) timeout_err <= 1'b1;
      end
   end

   assign state = st;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: each row pushes expected controls and
// post-edge register state, compared when the DUT produces them.
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        idex_memread = 1'b0;
   logic [4:0]  idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
   logic        branch_taken = 1'b0, imem_ready = 1'b1, dmem_busy = 1'b0;
   logic        pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze;
   logic [15:0] stall_cnt;
   logic        timeout_err;
   logic [1:0]  state;
   logic [4:0]  ctl;

   typedef struct packed {
      logic       mr;
      logic [4:0] rt, rs, rtt;
      logic       br, ir, db;
      logic [4:0] ctl;  // {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze}
      logic [1:0] st;
      logic       err;
   } row_t;

   typedef struct packed {
      logic [1:0]  st;
      logic [15:0] sc;
      logic        err;
   } reg_exp_t;

   logic [4:0] ctl_q[$];
   reg_exp_t   reg_q[$];
   logic [15:0] exp_sc = '0;
   int pass_cnt = 0, tot_cnt = 0;

   pipe_stall_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .idex_memread (idex_memread),
      .idex_rt      (idex_rt),
      .ifid_rs      (ifid_rs),
      .ifid_rt      (ifid_rt),
      .branch_taken (branch_taken),
      .imem_ready   (imem_ready),
      .dmem_busy    (dmem_busy),
      .pc_hold      (pc_hold),
      .ifid_hold    (ifid_hold),
      .ifid_flush   (ifid_flush),
      .idex_bubble  (idex_bubble),
      .pipe_freeze  (pipe_freeze),
      .stall_cnt    (stall_cnt),
      .timeout_err  (timeout_err),
      .state        (state)
   );

   always #5 clk = ~clk;

   assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze};

   // drive one cycle of stimulus and queue what the DUT should show for it
   task automatic apply(input row_t r);
      @(negedge clk);
      idex_memread = r.mr;
      idex_rt      = r.rt;
      ifid_rs      = r.rs;
      ifid_rt      = r.rtt;
      branch_taken = r.br;
      imem_ready   = r.ir;
      dmem_busy    = r.db;
      ctl_q.push_back(r.ctl);
      if (r.ctl[4] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
      reg_q.push_back('{r.st, exp_sc, r.err});
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      tot_cnt++;
      if ({state, stall_cnt, timeout_err} !== 19'd0)
         $display("FAIL rst_regs got st=%0d sc=%0d err=%b want 0/0/0", state, stall_cnt, timeout_err);
      else pass_cnt++;
      tot_cnt++;
      if (ctl !== 5'b00000) $display("FAIL rst_ctl got %b want 00000", ctl);
      else pass_cnt++;
      @(negedge clk);
      imem_ready = 1'b0;
      #1;
      tot_cnt++;
      if (ctl !== 5'b10100) $display("FAIL rst_comb_ctl got %b want 10100", ctl);
      else pass_cnt++;
      @(posedge clk); #1;
      tot_cnt++;
      if ({state, stall_cnt} !== 18'd0)
         $display("FAIL rst_hold got st=%0d sc=%0d want 0/0", state, stall_cnt);
      else pass_cnt++;
      @(negedge clk);
      imem_ready = 1'b1;
      rst_n      = 1'b1;
   endtask

   task automatic test_load_use();
      row_t t[5];
      logic [4:0] ec;
      reg_exp_t er;
      t = '{
         '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11010, 2'd0, 1'b0},
         '{1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 2'd0, 1'b0},
         '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 2'd0, 1'b0},
         '{1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 5'b11010, 2'd0, 1'b0},
         '{1'b1, 5'd7, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'b00000, 2'd0, 1'b0}};
      foreach (t[i]) begin
         apply(t[i]);
         #1; ec = ctl_q.pop_front(); tot_cnt++;
         if (ctl !== ec) $display("FAIL lu_ctl[%0d] got %b want %b", i, ctl, ec);
         else pass_cnt++;
         @(posedge clk); #1; er = reg_q.pop_front(); tot_cnt++;
         if ({state, stall_cnt, timeout_err} !== er)
            $display("FAIL lu_regs[%0d] got st=%0d sc=%0d err=%b want %0d/%0d/%b",
                     i, state, stall_cnt, timeout_err, er.st, er.sc, er.err);
         else pass_cnt++;
      end
   endtask

   task automatic test_branch_vs_lu();
      row_t t[3];
      logic [4:0] ec;
      reg_exp_t er;
      t = '{
         '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'b00110, 2'd0, 1'b0},
         '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b00110, 2'd0, 1'b0},
         '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 2'd0, 1'b0}};
      foreach (t[i]) begin
         apply(t[i]);
         #1; ec = ctl_q.pop_front(); tot_cnt++;
         if (ctl !== ec) $display("FAIL br_ctl[%0d] got %b want %b", i, ctl, ec);
         else pass_cnt++;
         @(posedge clk); #1; er = reg_q.pop_front(); tot_cnt++;
         if ({state, stall_cnt, timeout_err} !== er)
            $display("FAIL br_regs[%0d] got st=%0d sc=%0d err=%b want %0d/%0d/%b",
                     i, state, stall_cnt, timeout_err, er.st, er.sc, er.err);
         else pass_cnt++;
      end
   endtask

   task automatic test_imem_wait();
      row_t t[4];
      logic [4:0] ec;
      reg_exp_t er;
      t = '{
         '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b10100, 2'd1, 1'b0},
         '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b10100, 2'd1, 1'b0},
         '{1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'b10100, 2'd1, 1'b0},
         '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 2'd0, 1'b0}};
      foreach (t[i]) begin
         apply(t[i]);
         #1; ec = ctl_q.pop_front(); tot_cnt++;
         if (ctl !== ec) $display("FAIL imem_ctl[%0d] got %b want %b", i, ctl, ec);
         else pass_cnt++;
         @(posedge clk); #1; er = reg_q.pop_front(); tot_cnt++;
         if ({state, stall_cnt, timeout_err} !== er)
            $display("FAIL imem_regs[%0d] got st=%0d sc=%0d err=%b want %0d/%0d/%b",
                     i, state, stall_cnt, timeout_err, er.st, er.sc, er.err);
         else pass_cnt++;
      end
   endtask

   task automatic test_dmem_branch();
      row_t t[4];
      logic [4:0] ec;
      reg_exp_t er;
      t = '{
         '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'b11001, 2'd2, 1'b0},
         '{1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b1, 5'b11001, 2'd2, 1'b0},
         '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'b00110, 2'd0, 1'b0},
         '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 2'd0, 1'b0}};
      foreach (t[i]) begin
         apply(t[i]);
         #1; ec = ctl_q.pop_front(); tot_cnt++;
         if (ctl !== ec) $display("FAIL dmem_ctl[%0d] got %b want %b", i, ctl, ec);
         else pass_cnt++;
         @(posedge clk); #1; er = reg_q.pop_front(); tot_cnt++;
         if ({state, stall_cnt, timeout_err} !== er)
            $display("FAIL dmem_regs[%0d] got st=%0d sc=%0d err=%b want %0d/%0d/%b",
                     i, state, stall_cnt, timeout_err, er.st, er.sc, er.err);
         else pass_cnt++;
      end
   endtask

   // TIMEOUT=4: error must appear after the 5th busy edge and then stick
   task automatic test_timeout();
      row_t t[11];
      logic [4:0] ec;
      reg_exp_t er;
      for (int k = 0; k < 6; k++)
         t[k] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b11001, 2'd2, (k >= 4)};
      t[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 2'd0, 1'b1};
      t[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 2'd0, 1'b1};
      t[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b11001, 2'd2, 1'b1};
      t[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b10100, 2'd1, 1'b1};
      t[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 2'd0, 1'b1};
      foreach (t[i]) begin
         apply(t[i]);
         #1; ec = ctl_q.pop_front(); tot_cnt++;
         if (ctl !== ec) $display("FAIL to_ctl[%0d] got %b want %b", i, ctl, ec);
         else pass_cnt++;
         @(posedge clk); #1; er = reg_q.pop_front(); tot_cnt++;
         if ({state, stall_cnt, timeout_err} !== er)
            $display("FAIL to_regs[%0d] got st=%0d sc=%0d err=%b want %0d/%0d/%b",
                     i, state, stall_cnt, timeout_err, er.st, er.sc, er.err);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      dmem_busy = 1'b1;
      @(posedge clk); #1;
      tot_cnt++;
      if (state !== 2'd2) $display("FAIL mid_pre state got %0d want 2", state);
      else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      tot_cnt++;
      if ({state, stall_cnt, timeout_err} !== 19'd0)
         $display("FAIL mid_rst got st=%0d sc=%0d err=%b want 0/0/0", state, stall_cnt, timeout_err);
      else pass_cnt++;
      tot_cnt++;
      if (ctl !== 5'b11001) $display("FAIL mid_rst_ctl got %b want 11001", ctl);
      else pass_cnt++;
      @(negedge clk);
      dmem_busy = 1'b0;
      rst_n     = 1'b1;
      exp_sc    = '0;
      @(posedge clk); #1;
      tot_cnt++;
      if ({state, stall_cnt, timeout_err} !== 19'd0)
         $display("FAIL mid_post got st=%0d sc=%0d err=%b want 0/0/0", state, stall_cnt, timeout_err);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_vs_lu();
      test_imem_wait();
      test_dmem_branch();
      test_timeout();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall and flush controller for the 5-stage pipelined processor. It produces the hold signal that drives the program counter's `EN` input (1 = hold PC), plus IF/ID hold/flush, ID/EX bubble and back-end freeze controls. Sources are load-use hazards, taken branches, and multi-cycle instruction/data memory handshakes. It also keeps a saturating stall-cycle counter and a sticky memory-timeout error.

## Interface
- `TIMEOUT`, 255: max consecutive wait cycles on one memory before `timeout_err`; 1..65535.
- `CNT_W`, 16: width of `stall_cnt`.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `idex_memread`  in  1  instruction in ID/EX is a load
- `idex_rt`  in  5  load destination register
- `ifid_rs`, `ifid_rt`  in  5 each  source registers of instruction in IF/ID
- `branch_taken`  in  1  branch/jump resolved taken in EX
- `imem_ready`  in  1  instruction word for current PC valid this cycle
- `dmem_busy`  in  1  data memory access in MEM not complete
- `pc_hold`  out  1  to PC `EN`; 1 = PC keeps value
- `ifid_hold`  out  1  IF/ID keeps contents
- `ifid_flush`  out  1  IF/ID loads NOP
- `idex_bubble`  out  1  ID/EX loads NOP
- `pipe_freeze`  out  1  ID/EX, EX/MEM, MEM/WB keep contents
- `stall_cnt`  out  CNT_W  cycles with `pc_hold`=1, saturating
- `timeout_err`  out  1  sticky; cleared only by reset
- `state`  out  2  current FSM state (debug)

## Operation
- Load-use hazard: `lu = idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt)`.
- Priority per cycle, highest first:
  1. `dmem_busy`: `pipe_freeze`=`pc_hold`=`ifid_hold`=1, others 0.
  2. `branch_taken`: `ifid_flush`=`idex_bubble`=1, `pc_hold`=0; suppresses `lu` and imem wait (redirected PC refetches).
  3. `!imem_ready`: `pc_hold`=1, `ifid_flush`=1 (NOP enters ID), back-end advances.
  4. `lu`: `pc_hold`=`ifid_hold`=`idex_bubble`=1.
  5. Otherwise all controls 0.
- Controls are combinational from inputs (same cycle). The FSM only tracks wait episodes for the counter and timeout.
- FSM states: RUN=0, IMEM_WAIT=1, DMEM_WAIT=2.
  - RUN→DMEM_WAIT on `dmem_busy`.
  - RUN→IMEM_WAIT on `!imem_ready & !branch_taken & !dmem_busy`.
  - IMEM_WAIT→RUN on `imem_ready | branch_taken`.
  - IMEM_WAIT→DMEM_WAIT on `dmem_busy`.
  - DMEM_WAIT→RUN on `!dmem_busy`, or →IMEM_WAIT if also `!imem_ready`.
- Wait counter (16 bit): cleared on every state change and in RUN; increments each cycle in a wait state, saturating at TIMEOUT.
- `timeout_err` sets when the wait counter equals TIMEOUT.
- `stall_cnt` increments on every cycle with `pc_hold`=1 and saturates at all-ones.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=RUN; `stall_cnt`=0, wait counter=0, `timeout_err`=0.
  - During reset, combinational controls follow inputs; state-derived outputs are 0.
- Control latency: 0 cycles (input→output same cycle). Counter and FSM update on the next rising edge.
- Load-use stall lasts exactly 1 cycle: the next cycle `idex_memread`=0 because the bubble is in ID/EX.
- `branch_taken` together with `dmem_busy`: freeze wins. The branch stays in EX, so the flush occurs on the first cycle after `dmem_busy` falls.
- Reset mid-wait: FSM returns to RUN immediately and counters clear.

## Structure
- Shared package `pipe_ctrl_pkg`: state encoding constants (RUN/IMEM_WAIT/DMEM_WAIT) and the register-index width (5).
- One sub-module: `hazard_detect`, the combinational `lu` compare. It is reused by the forwarding unit.

## Test plan
- Reset: `rst_n`=0 mid-run → state=0, `stall_cnt`=0, `timeout_err`=0 immediately.
- Load-use: `idex_memread`=1, `idex_rt`=5, `ifid_rs`=5 → `pc_hold`=`ifid_hold`=`idex_bubble`=1 for one cycle, `stall_cnt`=1. With `idex_rt`=0 → no stall.
- Branch vs load-use same cycle: `branch_taken`=1, `lu` true → `ifid_flush`=`idex_bubble`=1, `pc_hold`=0.
- imem wait: `imem_ready`=0 for 3 cycles → `pc_hold`=1 and `ifid_flush`=1 each cycle, state=1, `stall_cnt`=3, then RUN.
- dmem freeze with branch: `dmem_busy`=1 for 2 cycles with `branch_taken`=1 → `pipe_freeze`=1, `ifid_flush`=0. The cycle after release → `ifid_flush`=1.
- Timeout: TIMEOUT=4, `dmem_busy` held 6 cycles → `timeout_err`=1 from cycle 5, still 1 after `dmem_busy` falls.
